// File: rtl/btn_scan_arbiter.sv
// Debounces N raw push-buttons with one shared stability timer: a round-robin
// scan visits one button per cycle and reports committed level changes over valid/ready.
module btn_scan_arbiter #(
  parameter int N_BTN = 4,
  parameter int IDXW  = 2,
  parameter int TIMES = 5000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDXW-1:0]  evt_idx,
  output logic             evt_press,
  output logic [N_BTN-1:0] btn_state
);

  localparam int CNTW = $clog2(TIMES + 1);

  typedef enum logic [1:0] {SCAN, CHECK, EMIT} state_e;

  state_e            state_q, state_d;
  logic [N_BTN-1:0]  sync1_q, sync2_q;
  logic [N_BTN-1:0]  btn_state_q, btn_state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d, ptr_inc;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              press_q, press_d;
  logic              cur_sync, changed, cnt_done;

  assign cur_sync = sync2_q[ptr_q];
  assign changed  = (cur_sync != btn_state_q[ptr_q]);
  assign cnt_done = (cnt_q == CNTW'(TIMES - 1));
  assign ptr_inc  = (ptr_q == IDXW'(N_BTN - 1)) ? '0 : ptr_q + IDXW'(1);

  // rst_n is expected to be released synchronously by the reset source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      sync1_q     <= '0;
      sync2_q     <= '0;
      btn_state_q <= '0;
      ptr_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      sync1_q     <= btn;
      sync2_q     <= sync1_q;
      btn_state_q <= btn_state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      press_q     <= press_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      SCAN:    if (changed) state_d = CHECK;
      CHECK: begin
        if (!changed)      state_d = SCAN;
        else if (cnt_done) state_d = EMIT;
      end
      EMIT:    if (evt_ready) state_d = SCAN;
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    btn_state_d = btn_state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    press_d     = press_q;
    unique case (state_q)
      SCAN: begin
        if (changed) cnt_d = '0;
        else         ptr_d = ptr_inc;
      end
      CHECK: begin
        if (!changed) begin
          ptr_d = ptr_inc;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_done) begin
            btn_state_d[ptr_q] = cur_sync;
            idx_d              = ptr_q;
            press_d            = cur_sync;
            valid_d            = 1'b1;
          end
        end
      end
      EMIT: begin
        if (evt_ready) begin
          valid_d = 1'b0;
          ptr_d   = ptr_inc;
        end
      end
      default: ;
    endcase
  end

  assign evt_valid = valid_q;
  assign evt_idx   = idx_q;
  assign evt_press = press_q;
  assign btn_state = btn_state_q;

endmodule

// File: tb/tb_btn_scan_arbiter.sv
// Directed bench for btn_scan_arbiter (N_BTN=4, TIMES=8): reset, debounce,
// glitch rejection, round-robin order, backpressure and mid-operation reset.
module tb_btn_scan_arbiter;

  localparam int N_BTN = 4;
  localparam int IDXW  = 2;
  localparam int TIMES = 8;
  localparam int LAT   = 2 + N_BTN + TIMES;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_BTN-1:0] btn;
  logic             evt_valid;
  logic             evt_ready;
  logic [IDXW-1:0]  evt_idx;
  logic             evt_press;
  logic [N_BTN-1:0] btn_state;

  int errors = 0;
  int checks = 0;
  int ev_idx[$];
  int ev_press[$];
  bit seen;

  btn_scan_arbiter #(.N_BTN(N_BTN), .IDXW(IDXW), .TIMES(TIMES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_idx   (evt_idx),
    .evt_press (evt_press),
    .btn_state (btn_state)
  );

  always #5 clk = ~clk;

  // Record every accepted event.
  always @(posedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      ev_idx.push_back(int'(evt_idx));
      ev_press.push_back(int'(evt_press));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      step(1);
      if (evt_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_events(input int n, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (ev_idx.size() >= n) break;
      step(1);
    end
    if (ev_idx.size() >= n) ok = 1'b1;
  endtask

  function automatic int ev_i(input int k);
    return (ev_idx.size() > k) ? ev_idx[k] : -1;
  endfunction

  function automatic int ev_p(input int k);
    return (ev_press.size() > k) ? ev_press[k] : -1;
  endfunction

  task automatic clear_events();
    ev_idx.delete();
    ev_press.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    btn       = 4'b1111;
    evt_ready = 1'b1;

    // 1: reset held with all buttons pressed
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("t1_valid_in_reset", evt_valid, 0);
      check("t1_state_in_reset", btn_state, 4'b0000);
    end
    btn = 4'b0000;
    step(1);
    rst_n = 1'b1;
    step(3);
    check("t1_valid_after_rel", evt_valid, 0);
    check("t1_no_events", ev_idx.size(), 0);

    // 2: single press of btn[1]
    clear_events();
    btn = 4'b0010;
    wait_valid(LAT, seen);
    check("t2_valid_latency", seen, 1);
    check("t2_idx", evt_idx, 1);
    check("t2_press", evt_press, 1);
    check("t2_state", btn_state, 4'b0010);
    step(1);
    check("t2_valid_one_cycle", evt_valid, 0);
    step(20);
    check("t2_event_count", ev_idx.size(), 1);
    check("t2_ev_idx", ev_i(0), 1);
    check("t2_ev_press", ev_p(0), 1);

    // 6a: release of btn[1]
    clear_events();
    btn = 4'b0000;
    wait_valid(LAT, seen);
    check("t6_rel_latency", seen, 1);
    check("t6_rel_idx", evt_idx, 1);
    check("t6_rel_press", evt_press, 0);
    check("t6_rel_state", btn_state, 4'b0000);
    step(3);

    // 3: glitches on btn[3] never reach TIMES stable cycles
    clear_events();
    btn[3] = 1'b1;
    step(5);
    btn[3] = 1'b0;
    step(12);
    for (int i = 0; i < 20; i++) begin
      btn[3] = ~btn[3];
      step(3);
    end
    btn = 4'b0000;
    step(20);
    check("t3_no_events", ev_idx.size(), 0);
    check("t3_state", btn_state, 4'b0000);
    check("t3_valid", evt_valid, 0);

    // 4: simultaneous rise of btn[0] and btn[2], seen first at ptr=0
    rst_n = 1'b0;
    step(2);
    check("t4_state_in_reset", btn_state, 4'b0000);
    rst_n = 1'b1;
    step(2);
    clear_events();
    btn = 4'b0101;
    wait_events(2, 60, seen);
    check("t4_two_events", seen, 1);
    check("t4_ev0_idx", ev_i(0), 0);
    check("t4_ev0_press", ev_p(0), 1);
    check("t4_ev1_idx", ev_i(1), 2);
    check("t4_ev1_press", ev_p(1), 1);
    check("t4_state", btn_state, 4'b0101);

    clear_events();
    btn = 4'b0000;
    wait_events(2, 60, seen);
    check("t4_release_events", seen, 1);
    check("t4_release_state", btn_state, 4'b0000);
    step(2);

    // 5: backpressure with a second press arriving during EMIT
    clear_events();
    evt_ready = 1'b0;
    btn = 4'b0010;
    wait_valid(LAT, seen);
    check("t5_valid_latency", seen, 1);
    btn = 4'b0110;
    for (int i = 0; i < 20; i++) begin
      check("t5_hold_valid", evt_valid, 1);
      check("t5_hold_idx", evt_idx, 1);
      check("t5_hold_press", evt_press, 1);
      step(1);
    end
    check("t5_no_handshake_yet", ev_idx.size(), 0);
    evt_ready = 1'b1;
    wait_events(2, 40, seen);
    check("t5_two_events", seen, 1);
    check("t5_ev0_idx", ev_i(0), 1);
    check("t5_ev0_press", ev_p(0), 1);
    check("t5_ev1_idx", ev_i(1), 2);
    check("t5_ev1_press", ev_p(1), 1);
    check("t5_state", btn_state, 4'b0110);

    // 6b: reset during CHECK with btn[1] held, then during EMIT
    rst_n = 1'b0;
    btn   = 4'b0010;
    step(2);
    check("t6_reset_state", btn_state, 4'b0000);
    clear_events();
    rst_n = 1'b1;
    step(8);
    check("t6_in_check_no_valid", evt_valid, 0);
    rst_n = 1'b0;
    #1;
    check("t6_chk_rst_valid", evt_valid, 0);
    check("t6_chk_rst_state", btn_state, 4'b0000);
    step(2);
    evt_ready = 1'b0;
    rst_n = 1'b1;
    wait_valid(LAT, seen);
    check("t6_fresh_latency", seen, 1);
    check("t6_fresh_idx", evt_idx, 1);
    check("t6_fresh_press", evt_press, 1);
    check("t6_fresh_state", btn_state, 4'b0010);
    rst_n = 1'b0;
    #1;
    check("t6_emit_rst_valid", evt_valid, 0);
    check("t6_emit_rst_state", btn_state, 4'b0000);
    step(2);
    evt_ready = 1'b1;
    rst_n = 1'b1;
    wait_events(1, 40, seen);
    check("t6_repress_event", seen, 1);
    check("t6_repress_idx", ev_i(0), 1);
    check("t6_repress_press", ev_p(0), 1);
    step(4);
    check("t6_repress_count", ev_idx.size(), 1);
    check("t6_final_state", btn_state, 4'b0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
